// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly in front of the instruction controller.
// It keeps the fetch PC, issues one read to instruction memory at a time,
// and presents each returned 16-bit instruction behind a valid/ready
// handshake. The instruction is also shown split into opcode and func
// fields. A one-cycle jump pulse redirects the fetch PC. It also squashes
// whatever instruction is being held or is still in flight at that moment.
//
// Ports
//   clk          in   1        single clock, all state on posedge
//   rst          in   1        synchronous, active-high reset
//   imem_req     out  1        read request, high for exactly one cycle per fetch
//   imem_addr    out  ADDR_W   read address, meaningful while imem_req=1
//   imem_rvalid  in   1        read data valid, at least one cycle after imem_req
//   imem_rdata   in   INSTR_W  read data, sampled while imem_rvalid=1
//   jump         in   1        one-cycle redirect pulse from the controller
//   jump_target  in   ADDR_W   redirect address, sampled while jump=1
//   instr_valid  out  1        instr/opcode/func/pc carry a live instruction
//   instr_ready  in   1        downstream accepts on instr_valid & instr_ready
//   instr        out  INSTR_W  registered instruction
//   opcode       out  4        instr[15:12]
//   func         out  8        instr[7:0]
//   pc           out  ADDR_W   address that instr was fetched from
//
// Operation
//   FETCH -> WAIT -> HOLD -> FETCH. With an immediate accept this gives
//   at most one instruction every three cycles. Only one read is ever
//   outstanding.
//
//   When a jump arrives while a read is outstanding, that read cannot be
//   cancelled. The squash flag marks its data to be thrown away when it
//   returns. The read of the redirected address is issued only after that.
//
//   INSTR_W must be 16, because the opcode and func fields sit at fixed bit
//   positions.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [7:0]         func,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // issue a read at fetch_pc this cycle
    S_WAIT  = 2'd1,  // read outstanding, waiting for imem_rvalid
    S_HOLD  = 2'd2   // instruction presented, waiting for the handshake
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic [ADDR_W-1:0]   fetch_pc_q;
  logic                squash_q;      // outstanding read belongs to a dead path
  logic                req_en_q;      // low for the first cycle after reset
  logic                instr_valid_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   pc_q;

  // Decoded control strobes for the datapath registers.
  logic                capture;       // latch returned data as a live instruction
  logic                accept;        // downstream handshake completes
  logic                drop;          // held instruction discarded by a jump
  logic                squash_set;
  logic                squash_clr;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments. Then all
  // registers sample the values that existed before the edge, whatever order
  // the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // A jump changes the flow only where it must:
  //   - In FETCH the request goes out anyway, so the FSM still moves to WAIT.
  //   - In WAIT, returning data (squashed or not) always sends the FSM back
  //     to FETCH.
  //   - In HOLD the held instruction is dropped.
  // NOTE: each combinational block assigns its default first. Then every path
  // through the block drives every output, and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        // The cycle straight after reset release is idle; the first request
        // goes out one cycle later.
        if (req_en_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = (jump || squash_q) ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD: begin
        if (jump || instr_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / control decode
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;
    capture    = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    squash_set = 1'b0;
    squash_clr = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = req_en_q;
        // A jump here cannot stop the read that is going out now, so its
        // data must be thrown away when it returns. If no request is going
        // out (idle cycle after reset), there is nothing to squash.
        squash_set = jump && req_en_q;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // Data from a squashed read, or data arriving together with a
          // jump, is dead. Returning data always ends the outstanding read.
          capture    = !squash_q && !jump;
          squash_clr = 1'b1;
        end else begin
          squash_set = jump;
        end
      end
      S_HOLD: begin
        accept = instr_ready && !jump;
        drop   = jump;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the instruction and pc registers are reset as well as the control
  // state. Downstream then sees a defined zero value before the first
  // instruction, not whatever the flops powered up with.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      squash_q      <= 1'b0;
      req_en_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
    end else begin
      req_en_q <= 1'b1;

      // The jump target is used exactly, with no increment. The increment
      // wraps silently at the top of the address space.
      if (jump) begin
        fetch_pc_q <= jump_target;
      end else if (capture) begin
        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
      end

      if (squash_clr) begin
        squash_q <= 1'b0;
      end else if (squash_set) begin
        squash_q <= 1'b1;
      end

      if (capture) begin
        instr_valid_q <= 1'b1;
        instr_q       <= imem_rdata;
        pc_q          <= fetch_pc_q;
      end else if (accept || drop) begin
        instr_valid_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Instruction outputs
  // -------------------------------------------------------------------------
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign opcode      = instr_q[15:12];
  assign func        = instr_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit.
//
// Two instances share the clock and reset:
//   u_dut_a  default RESET_PC; driven by the main directed sequence.
//   u_dut_b  RESET_PC = 12'hFFE; free-running with ready tied high, used to
//            observe PC wrap-around.
//
// Memory model: each instance has its own model that answers a request after
// a programmable number of cycles. The data comes from memd(), a fixed
// function of the address.
//
// Scoreboard: the expected request addresses and delivered instructions are
// queued before each phase. They are compared, in order, as the DUT issues
// requests and completes handshakes.
//
// Timing: everything happens in step(), at the falling edge.
//   1. Staged inputs are applied; they are sampled on the next rising edge.
//   2. The memory models update.
//   3. Outputs are compared.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        imem_req,    b_imem_req;
  logic [11:0] imem_addr,   b_imem_addr;
  logic        imem_rvalid, b_imem_rvalid;
  logic [15:0] imem_rdata,  b_imem_rdata;
  logic        jump;
  logic [11:0] jump_target;
  logic        instr_valid, b_instr_valid;
  logic        instr_ready;
  logic [15:0] instr,       b_instr;
  logic [3:0]  opcode,      b_opcode;
  logic [7:0]  func,        b_func;
  logic [11:0] pc,          b_pc;

  // Staged inputs; applied by step() at the next falling edge.
  logic        s_rst;
  logic        s_jump;
  logic [11:0] s_target;
  logic        s_ready;

  // Memory model for instance A.
  int          mem_lat;
  logic        a_ffff;      // force the next returned word to 16'hFFFF
  logic        a_pend;
  int          a_cnt;
  logic [11:0] a_addr;

  // Memory model for instance B.
  logic        b_pend;
  int          b_cnt;
  logic [11:0] b_addr;

  int          n_cmp;
  int          n_err;

  logic [11:0] addr_q[$];
  exp_t        ins_q[$];
  logic [11:0] b_addr_q[$];
  exp_t        b_ins_q[$];

  instr_fetch_unit u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .jump        (jump),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .pc          (pc)
  );

  instr_fetch_unit #(.RESET_PC(12'hFFE)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (b_imem_req),
    .imem_addr   (b_imem_addr),
    .imem_rvalid (b_imem_rvalid),
    .imem_rdata  (b_imem_rdata),
    .jump        (1'b0),
    .jump_target (12'h000),
    .instr_valid (b_instr_valid),
    .instr_ready (1'b1),
    .instr       (b_instr),
    .opcode      (b_opcode),
    .func        (b_func),
    .pc          (b_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory; address 0 holds 16'h8A47.
  function automatic logic [15:0] memd(input logic [11:0] a);
    return 16'h8A47 ^ ({4'h0, a} * 16'd41);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_req(input logic [11:0] a);
    addr_q.push_back(a);
  endtask

  task automatic exp_instr(input logic [11:0] a);
    exp_t e;
    e.pc   = a;
    e.data = memd(a);
    ins_q.push_back(e);
  endtask

  task automatic cmp_instr(input string who, input exp_t e, input logic [15:0] o_instr,
                           input logic [3:0] o_op, input logic [7:0] o_fn,
                           input logic [11:0] o_pc);
    check({who, "_instr"},  32'(o_instr), 32'(e.data));
    check({who, "_opcode"}, 32'(o_op),    32'(e.data[15:12]));
    check({who, "_func"},   32'(o_fn),    32'(e.data[7:0]));
    check({who, "_pc"},     32'(o_pc),    32'(e.pc));
  endtask

  task automatic step();
    exp_t        e;
    logic [11:0] ea;
    @(negedge clk);
    rst         = s_rst;
    jump        = s_jump;
    jump_target = s_target;
    instr_ready = s_ready;

    // Memory A: answer the pending read, then note any new request.
    imem_rvalid = 1'b0;
    if (a_pend) begin
      a_cnt--;
      if (a_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = a_ffff ? 16'hFFFF : memd(a_addr);
        a_pend      = 1'b0;
      end
    end
    if (imem_req) begin
      a_pend = 1'b1;
      a_cnt  = mem_lat;
      a_addr = imem_addr;
    end

    // Memory B: fixed one-cycle latency.
    b_imem_rvalid = 1'b0;
    if (b_pend) begin
      b_cnt--;
      if (b_cnt == 0) begin
        b_imem_rvalid = 1'b1;
        b_imem_rdata  = memd(b_addr);
        b_pend        = 1'b0;
      end
    end
    if (b_imem_req) begin
      b_pend = 1'b1;
      b_cnt  = 1;
      b_addr = b_imem_addr;
    end

    // Scoreboard A: request addresses.
    if (imem_req) begin
      if (addr_q.size() == 0) begin
        check("spurious_req", 32'(imem_req), 32'd0);
      end else begin
        ea = addr_q.pop_front();
        check("req_addr", 32'(imem_addr), 32'(ea));
      end
    end
    // Scoreboard A: delivered instructions. A jump or reset on the same edge
    // means the instruction is not delivered.
    if (instr_valid && instr_ready && !jump && !rst) begin
      if (ins_q.size() == 0) begin
        check("spurious_accept", 32'(instr_valid), 32'd0);
      end else begin
        e = ins_q.pop_front();
        cmp_instr("a", e, instr, opcode, func, pc);
      end
    end

    // Scoreboard B: only the first few transactions after reset are checked.
    if (b_imem_req && b_addr_q.size() != 0) begin
      ea = b_addr_q.pop_front();
      check("b_req_addr", 32'(b_imem_addr), 32'(ea));
    end
    if (b_instr_valid && !rst && b_ins_q.size() != 0) begin
      e = b_ins_q.pop_front();
      cmp_instr("b", e, b_instr, b_opcode, b_func, b_pc);
    end
  endtask

  initial begin
    exp_t eb;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; jump = 1'b0; jump_target = '0; instr_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; b_imem_rvalid = 1'b0; b_imem_rdata = '0;
    s_rst = 1'b1; s_jump = 1'b0; s_target = '0; s_ready = 1'b1;
    mem_lat = 1; a_ffff = 1'b0; a_pend = 1'b0; a_cnt = 0; a_addr = '0;
    b_pend = 1'b0; b_cnt = 0; b_addr = '0;

    // Instance B: the fetch PC wraps from FFF to 000.
    b_addr_q.push_back(12'hFFE);
    b_addr_q.push_back(12'hFFF);
    b_addr_q.push_back(12'h000);
    eb.pc = 12'hFFE; eb.data = memd(12'hFFE); b_ins_q.push_back(eb);
    eb.pc = 12'hFFF; eb.data = memd(12'hFFF); b_ins_q.push_back(eb);
    eb.pc = 12'h000; eb.data = memd(12'h000); b_ins_q.push_back(eb);

    // Test 1: two reset cycles, then sequential fetch from 0.
    exp_req(12'h000); exp_req(12'h001); exp_req(12'h002); exp_req(12'h003);
    exp_instr(12'h000); exp_instr(12'h001); exp_instr(12'h002);

    step();                                 // second reset cycle
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_imem_req",    32'(imem_req),    32'd0);
    check("rst_instr",       32'(instr),       32'd0);
    check("rst_pc",          32'(pc),          32'd0);
    s_rst = 1'b0;
    step();                                 // first cycle with rst low
    check("idle_after_release", 32'(imem_req), 32'd0);
    step();                                 // FETCH at address 0
    check("first_req", 32'(imem_req), 32'd1);
    step();                                 // WAIT, data returns
    step();                                 // HOLD, accepted
    check("opcode_8A47", 32'(opcode), 32'h8);
    check("func_8A47",   32'(func),   32'h47);
    repeat (5) step();                      // second fetch, then third up to its WAIT

    // Test 2: back-pressure for five cycles, then accept.
    s_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr),       32'(memd(12'h002)));
      check("stall_pc",    32'(pc),          32'h002);
      check("stall_noreq", 32'(imem_req),    32'd0);
    end
    s_ready = 1'b1;
    step();                                 // accepted on the sixth cycle
    step();                                 // next request straight after
    check("req_after_accept", 32'(imem_req), 32'd1);
    step();                                 // WAIT for address 3

    // Test 3: jump while holding, with ready high; there is no handshake.
    exp_req(12'h123); exp_instr(12'h123);
    s_jump = 1'b1; s_target = 12'h123;
    step();
    check("hold_before_jump", 32'(instr_valid), 32'd1);
    s_jump = 1'b0;
    step();                                 // FETCH at 0x123
    check("valid_after_hold_jump", 32'(instr_valid), 32'd0);
    step();
    step();                                 // 0x123 accepted

    // Test 4a: jump in WAIT; the squashed data arrives two cycles later.
    exp_req(12'h124); exp_req(12'h200); exp_instr(12'h200);
    mem_lat = 3; a_ffff = 1'b1;
    step();                                 // request at 0x124
    s_jump = 1'b1; s_target = 12'h200;
    step();                                 // jump in WAIT
    s_jump = 1'b0;
    step();
    step();                                 // 16'hFFFF returns, is discarded
    a_ffff = 1'b0; mem_lat = 1;
    step();                                 // FETCH at 0x200
    check("squash_valid_a", 32'(instr_valid), 32'd0);
    check("squash_req_a",   32'(imem_req),    32'd1);
    step();
    step();                                 // 0x200 accepted

    // Test 4b: jump and data arrive in the same cycle.
    exp_req(12'h201); exp_req(12'h300); exp_instr(12'h300);
    a_ffff = 1'b1;
    step();                                 // request at 0x201
    s_jump = 1'b1; s_target = 12'h300;
    step();                                 // rvalid together with jump
    s_jump = 1'b0; a_ffff = 1'b0;
    step();                                 // FETCH at 0x300
    check("squash_valid_b", 32'(instr_valid), 32'd0);
    check("squash_req_b",   32'(imem_req),    32'd1);
    step();
    step();                                 // 0x300 accepted

    // Test 6a: reset while in WAIT. The late data then arrives outside WAIT.
    exp_req(12'h301); exp_req(12'h000);
    mem_lat = 2;
    step();                                 // request at 0x301
    s_rst = 1'b1;
    step();                                 // WAIT, reset sampled
    s_rst = 1'b0; mem_lat = 1;
    step();
    check("rst_wait_valid", 32'(instr_valid), 32'd0);
    check("rst_wait_req",   32'(imem_req),    32'd0);
    step();
    check("rst_wait_refetch", 32'(imem_req), 32'd1);
    step();                                 // WAIT, data for address 0

    // Test 6b: reset while in HOLD.
    exp_req(12'h000); exp_instr(12'h000);
    s_rst = 1'b1; s_ready = 1'b0;
    step();
    check("hold_before_rst", 32'(instr_valid), 32'd1);
    s_rst = 1'b0; s_ready = 1'b1;
    step();
    check("rst_hold_valid", 32'(instr_valid), 32'd0);
    check("rst_hold_req",   32'(imem_req),    32'd0);
    step();
    check("rst_hold_refetch", 32'(imem_req), 32'd1);
    step();
    step();                                 // address 0 accepted

    check("a_reqs_left",   32'(addr_q.size()),   32'd0);
    check("a_instrs_left", 32'(ins_q.size()),    32'd0);
    check("b_reqs_left",   32'(b_addr_q.size()), 32'd0);
    check("b_instrs_left", 32'(b_ins_q.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
